// File: rtl/ppm_pkg.sv
// ppm_pkg: shared state encoding and widths for the PPM transmit scheduler
package ppm_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, HOLD} state_t;
  localparam int PPM_BYTE_W = 8;
  localparam int PPM_LEN_W = 4;
  localparam int HOLD_W = 16;
endpackage

// File: rtl/ppm_rr_arb2.sv
// ppm_rr_arb2: two-request round-robin arbiter, priority flips to the loser on advance
module ppm_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic prio;
  assign gnt = prio ? (req[1] ? 2'b10 : {1'b0, req[0]}) : (req[0] ? 2'b01 : {req[1], 1'b0});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= 1'b0;
    else if (advance) prio <= gnt[0];
endmodule

// File: rtl/ppm_tx_scheduler.sv
// ppm_tx_scheduler: round-robin frame scheduler sharing one PPM encoder between two byte streams
module ppm_tx_scheduler
  import ppm_pkg::*;
#(
  parameter int HOLD_PER_BYTE = 16,
  parameter int IDLE_MIN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [PPM_LEN_W-1:0]  len0,
  input  logic [PPM_LEN_W-1:0]  len1,
  input  logic [PPM_BYTE_W-1:0] dat0,
  input  logic [PPM_BYTE_W-1:0] dat1,
  input  logic [1:0]            dat_valid,
  output logic [1:0]            dat_ready,
  output logic [1:0]            grant,
  output logic [1:0]            done,
  output logic                  underrun,
  output logic                  busy,
  output logic                  Le,
  output logic [PPM_LEN_W-1:0]  N,
  output logic [PPM_BYTE_W-1:0] Din
);
  state_t state, state_nx;
  logic [1:0] arb_gnt;
  logic [PPM_LEN_W-1:0] len_sel, len_q;
  logic [HOLD_W-1:0] cnt, hold_ld;
  logic start, hdr_go, pop_en, val_sel;
  logic [PPM_BYTE_W-1:0] dat_sel;
  ppm_rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req(req), .advance(start), .gnt(arb_gnt));
  assign start = state == IDLE && |req;
  assign len_sel = arb_gnt[1] ? len1 : len0;
  assign hdr_go = start && len_sel != '0;
  assign dat_sel = grant[1] ? dat1 : dat0;
  assign val_sel = dat_valid[grant[1]];
  // HOLD spans exactly IDLE_MIN + HOLD_PER_BYTE*len cycles, so the count runs down to 0 from one less
  assign hold_ld = HOLD_W'(IDLE_MIN + HOLD_PER_BYTE * int'(len_q) - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = hdr_go ? HDR : IDLE;
      HDR: state_nx = DATA;
      DATA: state_nx = cnt == '0 ? HOLD : DATA;
      HOLD: state_nx = cnt == '0 ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    pop_en = state == HDR || (state == DATA && cnt != '0);
    dat_ready = pop_en ? grant : 2'b00;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Le <= 1'b0;
      N <= '0;
      Din <= '0;
      underrun <= 1'b0;
      grant <= 2'b00;
      done <= 2'b00;
      len_q <= '0;
      cnt <= '0;
    end else begin
      Le <= hdr_go;
      N <= hdr_go ? len_sel : '0;
      Din <= pop_en && val_sel ? dat_sel : '0;
      underrun <= pop_en && !val_sel;
      if (start) begin
        grant <= arb_gnt;
        len_q <= len_sel;
      end else if (state == IDLE || (state == HOLD && cnt == '0)) grant <= 2'b00;
      done <= start && len_sel == '0 ? arb_gnt : (state == HOLD && cnt == HOLD_W'(1)) ? grant : 2'b00;
      cnt <= state == HDR ? HOLD_W'(len_q) - HOLD_W'(1) : (state == DATA && cnt == '0) ? hold_ld : cnt - HOLD_W'(1);
    end
endmodule

// File: tb/tb_ppm_tx_scheduler.sv
// tb_ppm_tx_scheduler: frame-timeline reference model checking the scheduler under directed and random traffic
module tb_ppm_tx_scheduler;
  localparam int HPB = 16;
  localparam int IMIN = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req = 2'b00, dat_valid = 2'b00;
  logic [3:0] len0 = '0, len1 = '0;
  logic [7:0] dat0 = '0, dat1 = '0;
  logic [1:0] dat_ready, grant, done;
  logic underrun, busy, Le;
  logic [3:0] N;
  logic [7:0] Din;
  ppm_tx_scheduler #(.HOLD_PER_BYTE(HPB), .IDLE_MIN(IMIN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1), .dat0(dat0), .dat1(dat1),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .grant(grant), .done(done), .underrun(underrun),
    .busy(busy), .Le(Le), .N(N), .Din(Din)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  // frame model: a grant sampled at the end of cycle t0 lays out the whole frame as offsets k = cycle - t0
  bit act = 0, prio = 0, rnd_v = 0;
  int t0 = 0, L = 0, H = 0, g = 0, c = 0, drop_pop = -1;
  logic [7:0] exp_b[16];
  bit exp_u[16];
  logic [7:0] q0[$], q1[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    int k, endk, pi, wn;
    logic [1:0] eg;
    bit in_data;
    k = c - t0;
    endk = L > 0 ? 1 + L + H : 1;
    pi = (act && L > 0 && k >= 1 && k <= L) ? k - 1 : -1;
    for (int i = 0; i < 2; i++) dat_valid[i] = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (pi >= 0 && pi == drop_pop) dat_valid[g] = 1'b0;
    dat0 = q0.size() > 0 ? q0[0] : 8'($urandom);
    dat1 = q1.size() > 0 ? q1[0] : 8'($urandom);
    eg = 2'(1 << g);
    in_data = act && L > 0 && k >= 2 && k <= 1 + L;
    chk("grant", grant, (act && k >= 1 && k <= endk) ? eg : 2'b00);
    chk("busy", busy, act && L > 0 && k >= 1 && k <= endk);
    chk("le", Le, act && L > 0 && k == 1);
    chk("n", N, (act && L > 0 && k == 1) ? L : 0);
    chk("ready", dat_ready, pi >= 0 ? eg : 2'b00);
    chk("din", Din, in_data ? exp_b[k-2] : 8'h00);
    chk("underrun", underrun, in_data ? exp_u[k-2] : 1'b0);
    chk("done", done, (act && k == endk) ? eg : 2'b00);
    if (pi >= 0) begin
      exp_b[pi] = dat_valid[g] ? (g == 1 ? dat1 : dat0) : 8'h00;
      exp_u[pi] = !dat_valid[g];
      if (dat_valid[g]) begin
        if (g == 0 && q0.size() > 0) void'(q0.pop_front());
        else if (g == 1 && q1.size() > 0) void'(q1.pop_front());
      end
    end
    if (!rst_n || (act && k >= endk + (L > 0 ? 1 : 0))) act = 0;
    if (!act && rst_n && req != 2'b00) begin
      wn = (req == 2'b11) ? int'(prio) : (req[1] ? 1 : 0);
      act = 1;
      t0 = c;
      g = wn;
      L = wn == 1 ? int'(len1) : int'(len0);
      H = IMIN + HPB * L;
      prio = (wn == 0);
    end
    c++;
    @(negedge clk);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic drain();
    int n = 0;
    while (act && n < 2000) begin
      step();
      n++;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    // 4-byte frame from requester 0, request dropped during the header cycle
    q0 = '{8'hC0, 8'hAA, 8'hDD, 8'hAE};
    len0 = 4'd4;
    req = 2'b01;
    step();
    req = 2'b00;
    drain();
    // zero-length frame on requester 1, then contention with requester 0 holding priority
    len1 = 4'd0;
    req = 2'b10;
    step();
    len0 = 4'd2;
    len1 = 4'd2;
    q0 = '{8'h11, 8'h12, 8'h13, 8'h14};
    q1 = '{8'h21, 8'h22, 8'h23, 8'h24};
    req = 2'b11;
    run(150);
    req = 2'b00;
    drain();
    // missing byte on the third pop
    len0 = 4'd4;
    q0 = '{8'h01, 8'h02, 8'h03, 8'h04};
    drop_pop = 2;
    req = 2'b01;
    step();
    req = 2'b00;
    drain();
    drop_pop = -1;
    // reset in the middle of DATA
    len0 = 4'd4;
    req = 2'b01;
    step();
    req = 2'b00;
    run(3);
    rst_n = 1'b0;
    #1;
    chk("rst_le", Le, 0);
    chk("rst_n_hdr", N, 0);
    chk("rst_din", Din, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", dat_ready, 0);
    act = 0;
    prio = 0;
    run(2);
    rst_n = 1'b1;
    len0 = 4'd3;
    len1 = 4'd5;
    q0 = '{8'h31, 8'h32, 8'h33};
    req = 2'b11;
    step();
    req = 2'b00;
    drain();
    // short frame after a quiet period
    len0 = 4'd3;
    q0 = '{8'h5A, 8'hA5, 8'h3C};
    req = 2'b01;
    step();
    req = 2'b00;
    drain();
    // random traffic with random byte validity
    rnd_v = 1;
    repeat (25) begin
      req = 2'($urandom_range(0, 3));
      len0 = 4'($urandom_range(0, 5));
      len1 = 4'($urandom_range(0, 5));
      run($urandom_range(1, 40));
    end
    req = 2'b00;
    drain();
    run(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ppm_tx_scheduler.md
# ppm_tx_scheduler

Transmit-side frame scheduler for the PPM link. It shares the single `encoder` instance between two byte-stream requesters using round-robin arbitration. For each granted frame it issues the one-cycle `Le`/`N` frame header, streams exactly `N` bytes on `Din` on consecutive cycles, then holds off new frames while the encoder serializes. It sits directly in front of `encoder`; its `Le`/`N`/`Din` outputs connect one-to-one to the encoder inputs.

## Interface
- `HOLD_PER_BYTE`, 16: idle cycles added per byte after a frame, covering encoder serialization.
- `IDLE_MIN`, 4: fixed idle cycles after every frame, on top of the per-byte hold.
- `clk`  in  1  system clock; same clock as `encoder`/`PPM`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester frame request; level, sampled only in IDLE.
- `len0`, `len1`  in  4 each  frame length in bytes for requester 0/1; sampled with the grant.
- `dat0`, `dat1`  in  8 each  byte presented by requester 0/1.
- `dat_valid`  in  2  per-requester byte valid.
- `dat_ready`  out  2  per-requester byte pop; a byte transfers when valid and ready are both high.
- `grant`  out  2  one-hot; held high from the grant edge until frame completion.
- `done`  out  2  one-cycle pulse per requester at frame completion.
- `underrun`  out  1  one-cycle pulse when a required byte was not valid.
- `busy`  out  1  high in every state except IDLE.
- `Le`, `N`, `Din`  out  1/4/8  encoder frame header and data; all registered.

## Operation
- States:
  - IDLE: no frame in progress.
  - HDR: one cycle; frame header on `Le`/`N`.
  - DATA: `len` cycles; bytes on `Din`.
  - HOLD: counted idle before the next frame.
- IDLE: if any `req` bit is high, the round-robin arbiter picks one requester.
  - After reset, requester 0 has priority. After each grant, the other requester has priority.
  - On the edge: latch `len`, set `grant`.
  - If `len` != 0, go to HDR. If `len` == 0, pulse `done` and stay in IDLE (no header, no hold, priority still rotates).
- HDR: `Le`=1, `N`=len, `Din`=0.
  - `dat_ready[g]` is high during this cycle to pop byte 0 into the `Din` register.
- DATA: `Din` shows byte k during cycle k (k = 0..len-1); `Le`=0, `N`=0.
  - `dat_ready[g]` is high in HDR and in DATA cycles 0..len-2. That is exactly `len` pops, with no pop in the last DATA cycle.
  - If `dat_valid[g]` is low at a pop, that byte is sent as 8'h00 and `underrun` pulses in the cycle that byte appears on `Din`. The frame continues.
- HOLD: `Din`=0. The counter loads `IDLE_MIN + HOLD_PER_BYTE*len` (16-bit, no overflow for legal parameters) and counts down.
  - At 0: pulse `done[g]`, drop `grant`, return to IDLE.
  - A request may be granted in the cycle after return.
- `req` deasserting after the grant is ignored; the frame completes.
- Bytes on the non-granted port are never popped.

## Timing
- Reset values: `Le`=0, `N`=0, `Din`=0, `grant`=0, `done`=0, `underrun`=0, `busy`=0, `dat_ready`=0, state IDLE, priority to requester 0.
- Reset is asynchronous and applies mid-frame as well: outputs clear immediately and the frame is dropped with no `done`.
- `req` sampled high at edge t gives `grant` and `busy` high after t, and `Le` high in cycle t+1.
- First data byte is on `Din` in cycle t+2; last byte is in cycle t+1+len.
- `done` pulses in the final HOLD cycle, i.e. `IDLE_MIN + HOLD_PER_BYTE*len` cycles after the last DATA cycle.
- Minimum request-to-request spacing for len L is 1 + 1 + L + `IDLE_MIN` + `HOLD_PER_BYTE*L` cycles.
- `dat_ready` is combinational from state and counter only, never from `dat_valid`.
- If both requesters request in the same IDLE cycle, the priority holder wins. The loser keeps requesting and is granted on the next IDLE cycle.

## Structure
- Package `ppm_pkg` holds:
  - the state enum (IDLE/HDR/DATA/HOLD);
  - `PPM_BYTE_W`=8 and `PPM_LEN_W`=4;
  - the hold-counter width of 16.
- Sub-module `ppm_rr_arb2`: two-request round-robin arbiter. It has a priority register, a one-hot grant output and an `advance` input pulsed on grant.

## Test plan
- Reset, then `req`=01, `len0`=4, bytes C0,AA,DD,AE always valid → `Le`=1/`N`=4 for one cycle, then `Din` C0,AA,DD,AE on consecutive cycles, `done[0]` after 4+64 idle cycles.
- `req`=11 held, both len 2 → grants alternate 0,1,0,1; each frame keeps its own bytes and never pops the other port.
- `len1`=0 with `req`=10 → `done[1]` one cycle after the grant; `Le` never asserts; next grant goes to requester 0.
- `dat_valid[0]` low on the third pop of a 4-byte frame → third `Din` byte is 00, `underrun` pulses with it, and the frame length is unchanged.
- `rst_n` low during DATA → `Le`/`N`/`Din`/`grant` cleared asynchronously, no `done`; after release the first request is served normally with requester 0 priority.
- `req[0]` dropped in the HDR cycle → the full frame is still sent and `done[0]` pulses.
